// File: rtl/occ_pkg.sv
// Shared definitions for the lot occupancy tracker: converter states, BCD constants and the
// double-dabble nibble adjust helper.
package occ_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } dd_state_e;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [3:0] BCD_ADJ    = 4'd3;
  localparam logic [3:0] BCD_THRESH = 4'd5;

  // Adds 3 to every nibble that would overflow past 9 on the next left shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (s[4*i +: 4] >= BCD_THRESH) r[4*i +: 4] = s[4*i +: 4] + BCD_ADJ;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dd_engine.sv
// Multi-cycle double-dabble binary-to-BCD converter with a start/busy/done handshake.
// One conversion takes CNT_W shift cycles plus a single DONE cycle.
module bcd_dd_engine
  import occ_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic [CNT_W-1:0] val
);

  localparam int CW = $clog2(CNT_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(CNT_W - 1);

  dd_state_e        state;
  logic [CNT_W-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [CW-1:0]    bit_cnt;

  assign bcd = scratch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      val     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= din;
            val     <= din;
            scratch <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {scratch, shreg} <= {dd_adjust(scratch), shreg} << 1;
          bit_cnt          <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lot_occupancy_tracker.sv
// Saturating parking-lot occupancy counter with full/empty flags and BCD digit output.
// Define OCC_ERR_EN to add the sticky err output for overflow/underflow attempts.
module lot_occupancy_tracker
  import occ_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CAPACITY = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enter,
  input  logic             exit,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic             bcd_valid,
  output logic             full,
  output logic             empty
`ifdef OCC_ERR_EN
  ,
  output logic             err
`endif
);

  logic [CNT_W-1:0] cnt_d;
  logic             inc, dec;
  logic [CNT_W-1:0] snap;
  logic             start;
  logic             dd_busy, dd_done;
  logic [BCD_W-1:0] dd_bcd;
  logic [CNT_W-1:0] dd_val;

  // full/empty track the count register, so they gate saturation without extra compares.
  assign inc = enter & ~exit & ~full;
  assign dec = exit & ~enter & ~empty;

  always_comb begin
    cnt_d = count;
    if (inc)      cnt_d = count + 1'b1;
    else if (dec) cnt_d = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= cnt_d;
      full  <= (cnt_d == CNT_W'(CAPACITY));
      empty <= (cnt_d == '0);
    end
  end

  assign start = ~dd_busy & (snap != count);

  bcd_dd_engine #(
    .CNT_W(CNT_W)
  ) u_dd (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .din  (count),
    .busy (dd_busy),
    .done (dd_done),
    .bcd  (dd_bcd),
    .val  (dd_val)
  );

  // Digits are only ever loaded from a finished conversion, so they never show a torn value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap      <= '0;
      dig0      <= '0;
      dig1      <= '0;
      dig2      <= '0;
      bcd_valid <= 1'b1;
    end else if (start) begin
      bcd_valid <= 1'b0;
    end else if (dd_done) begin
      dig0      <= dd_bcd[3:0];
      dig1      <= dd_bcd[7:4];
      dig2      <= dd_bcd[11:8];
      snap      <= dd_val;
      bcd_valid <= (dd_val == count);
    end
  end

`ifdef OCC_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((enter & ~exit & full) | (exit & ~enter & empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lot_occupancy_tracker.sv
// Self-checking bench for lot_occupancy_tracker: vector table, directed corner sequences and
// randomized traffic against a saturating-count reference model.
module tb_lot_occupancy_tracker;

  localparam int CNT_W = 8;
  localparam int CAP   = 99;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enter = 1'b0;
  logic             exit = 1'b0;
  logic [CNT_W-1:0] count;
  logic [3:0]       dig0, dig1, dig2;
  logic             bcd_valid, full, empty;
`ifdef OCC_ERR_EN
  logic             err;
`endif

  always #5 clk = ~clk;

  lot_occupancy_tracker #(
    .CNT_W   (CNT_W),
    .CAPACITY(CAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enter    (enter),
    .exit     (exit),
    .count    (count),
    .dig0     (dig0),
    .dig1     (dig1),
    .dig2     (dig2),
    .bcd_valid(bcd_valid),
    .full     (full),
    .empty    (empty)
`ifdef OCC_ERR_EN
    ,
    .err      (err)
`endif
  );

  typedef struct {
    bit e;
    bit x;
    int exp_cnt;
    bit exp_full;
    bit exp_empty;
    bit exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  bit m_err  = 0;
  bit seen[1000];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_err = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    seen[0] = 1'b1;
  endtask

  // Displayed digits must always be a legal BCD rendering of some value count has held.
  task automatic chk_torn();
    int v;
    checks++;
    v = int'(dig2) * 100 + int'(dig1) * 10 + int'(dig0);
    if (dig0 > 9 || dig1 > 9 || dig2 > 9 || !seen[v]) begin
      errors++;
      $display("FAIL torn_digits actual=%0d%0d%0d expected=a previously held count", dig2,
               dig1, dig0);
    end
  endtask

  task automatic step(input bit e, input bit x);
    @(negedge clk);
    chk_torn();
    enter = e;
    exit  = x;
    @(posedge clk);
    #1;
    if (e && !x && m_cnt == CAP) m_err = 1'b1;
    if (x && !e && m_cnt == 0)   m_err = 1'b1;
    if (e && !x && m_cnt < CAP)  m_cnt = m_cnt + 1;
    else if (x && !e && m_cnt > 0) m_cnt = m_cnt - 1;
    seen[m_cnt] = 1'b1;
    enter = 1'b0;
    exit  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, int'(count), m_cnt);
    chk({tag, "_full"}, int'(full), int'(m_cnt == CAP));
    chk({tag, "_empty"}, int'(empty), int'(m_cnt == 0));
`ifdef OCC_ERR_EN
    chk({tag, "_err"}, int'(err), int'(m_err));
`endif
  endtask

  task automatic chk_dig(input string tag, input int d2, input int d1, input int d0);
    chk({tag, "_dig2"}, int'(dig2), d2);
    chk({tag, "_dig1"}, int'(dig1), d1);
    chk({tag, "_dig0"}, int'(dig0), d0);
  endtask

  task automatic chk_model_dig(input string tag);
    chk_dig(tag, m_cnt / 100, (m_cnt / 10) % 10, m_cnt % 10);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    step(1'b0, 1'b0);
    while (!bcd_valid && n < 3 * (CNT_W + 3)) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("settle_valid", int'(bcd_valid), 1);
  endtask

  task automatic do_reset();
    enter = 1'b0;
    exit  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1};

    // Reset values
    do_reset();
    #1;
    check_state("reset");
    chk("reset_valid", int'(bcd_valid), 1);
    chk_dig("reset", 0, 0, 0);

    // Twelve spaced entries
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end
    wait_valid();
    check_state("twelve");
    chk_dig("twelve", 0, 1, 2);

    // Exact conversion latency from a quiet converter
    step(1'b1, 1'b0);
    repeat (CNT_W + 1) step(1'b0, 1'b0);
    chk("latency_early_valid", int'(bcd_valid), 0);
    step(1'b0, 1'b0);
    chk("latency_valid", int'(bcd_valid), 1);
    chk_dig("latency", 0, 1, 3);

    // Fill to capacity and push past it
    while (m_cnt < CAP) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check_state("sat_full");
    chk("sat_count_const", int'(count), CAP);
    wait_valid();
    chk_dig("sat_full", 0, 9, 9);

    // Underflow / simultaneous-tick vectors from an empty lot
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].e, tbl[i].x);
      chk($sformatf("vec%0d_count", i), int'(count), tbl[i].exp_cnt);
      chk($sformatf("vec%0d_full", i), int'(full), int'(tbl[i].exp_full));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(tbl[i].exp_empty));
`ifdef OCC_ERR_EN
      chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].exp_err));
`endif
    end

    // Back-to-back entries while converting
    do_reset();
    repeat (7) step(1'b1, 1'b0);
    wait_valid();
    check_state("burst");
    chk_dig("burst", 0, 0, 7);

    // Asynchronous reset during SHIFT at count 45
    do_reset();
    repeat (44) step(1'b1, 1'b0);
    wait_valid();
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 45);
    chk("pre_rst_valid", int'(bcd_valid), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_valid", int'(bcd_valid), 1);
    chk("async_empty", int'(empty), 1);
    chk("async_full", int'(full), 0);
    chk_dig("async", 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < CNT_W + 4; i++) begin
      step(1'b0, 1'b0);
      chk("post_rst_valid", int'(bcd_valid), 1);
      chk("post_rst_digits", int'(dig2) * 100 + int'(dig1) * 10 + int'(dig0), 0);
    end

    // Randomized traffic: upward-biased, then downward-biased
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 300; i++) begin
        int unsigned r;
        bit e, x;
        r = $urandom_range(0, 9);
        if (ph == 0) begin
          e = (r <= 6);
          x = (r == 6) || (r == 9);
        end else begin
          x = (r <= 6);
          e = (r == 6) || (r == 9);
        end
        step(e, x);
        check_state("rand");
        if (i % 75 == 74) begin
          wait_valid();
          chk_model_dig("rand");
        end
      end
    end
    wait_valid();
    chk_model_dig("rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
